// File: rtl/pe_weight_loader.sv
// Control stage in front of one weight-stationary PE. It streams weights into the
// scratchpad, then fetches and latches one weight and sequences the accumulate beats.
module pe_weight_loader #(
  parameter int MEM_ADDR_BITWIDTH = 10,
  parameter int WGT_BITWIDTH      = 8,
  parameter int LEN_BITWIDTH      = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wgt_in_valid,
  output logic                         wgt_in_ready,
  input  logic [WGT_BITWIDTH-1:0]      wgt_in_data,
  input  logic                         wgt_in_last,
  input  logic                         load_start,
  input  logic                         comp_start,
  input  logic [MEM_ADDR_BITWIDTH-1:0] sel_addr,
  input  logic [LEN_BITWIDTH-1:0]      comp_len,
  input  logic                         act_valid,
  output logic                         write_req_w_mem,
  output logic [MEM_ADDR_BITWIDTH-1:0] w_addr_w_mem,
  output logic [WGT_BITWIDTH-1:0]      w_data_w_mem,
  output logic                         read_req_w_mem,
  output logic [MEM_ADDR_BITWIDTH-1:0] r_addr_w_mem,
  output logic                         reset_ws_reg,
  output logic                         ws_en,
  output logic                         ws_mux,
  output logic                         wrt_en_reg,
  output logic [MEM_ADDR_BITWIDTH:0]   loaded_count,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_CAPTURE,
    S_COMPUTE
  } state_t;

  localparam logic [MEM_ADDR_BITWIDTH:0] LP_LAST_SLOT = {1'b0, {MEM_ADDR_BITWIDTH{1'b1}}};
  localparam logic [MEM_ADDR_BITWIDTH:0] LP_CNT_ONE   = {{MEM_ADDR_BITWIDTH{1'b0}}, 1'b1};
  localparam logic [LEN_BITWIDTH-1:0]    LP_BEAT_ONE  = {{(LEN_BITWIDTH-1){1'b0}}, 1'b1};

  state_t                         r_state;
  logic [MEM_ADDR_BITWIDTH:0]     r_loaded_count;
  logic [MEM_ADDR_BITWIDTH-1:0]   r_rd_addr;
  logic [LEN_BITWIDTH-1:0]        r_len;
  logic [LEN_BITWIDTH-1:0]        r_beat;
  logic                           r_done;
  logic                           r_err;

  logic                           w_wr_fire;
  logic                           w_last_slot;
  logic                           w_cmd_bad;
  logic                           w_in_pass;
  logic [LEN_BITWIDTH-1:0]        w_beat_next;

  // The load counter doubles as the write address; it never wraps because the
  // burst is cut off after the top slot is written.
  assign w_wr_fire   = wgt_in_valid && (r_state == S_LOAD);
  assign w_last_slot = (r_loaded_count == LP_LAST_SLOT);
  assign w_cmd_bad   = (comp_len == '0) || ({1'b0, sel_addr} >= r_loaded_count);
  assign w_in_pass   = (r_state == S_CAPTURE) || (r_state == S_COMPUTE);
  assign w_beat_next = r_beat + LP_BEAT_ONE;

  assign wgt_in_ready    = (r_state == S_LOAD);
  assign write_req_w_mem = w_wr_fire;
  assign w_addr_w_mem    = w_wr_fire ? r_loaded_count[MEM_ADDR_BITWIDTH-1:0] : '0;
  assign w_data_w_mem    = w_wr_fire ? wgt_in_data : '0;
  assign read_req_w_mem  = (r_state == S_FETCH);
  assign reset_ws_reg    = (r_state == S_FETCH);
  assign r_addr_w_mem    = r_rd_addr;
  assign ws_en           = (r_state == S_CAPTURE);
  assign ws_mux          = (r_state == S_CAPTURE);
  assign wrt_en_reg      = act_valid && w_in_pass;
  assign loaded_count    = r_loaded_count;
  assign busy            = (r_state != S_IDLE);
  assign done            = r_done;
  assign err             = r_err;

  // NOTE: all state lives in this one block and uses non-blocking assignments, so
  // every decision below sees the pre-edge register values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_loaded_count <= '0;
      r_rd_addr      <= '0;
      r_len          <= '0;
      r_beat         <= '0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_state        <= S_LOAD;
            r_loaded_count <= '0;
          end else if (comp_start) begin
            if (w_cmd_bad) begin
              r_err <= 1'b1;
            end else begin
              r_state   <= S_FETCH;
              r_rd_addr <= sel_addr;
              r_len     <= comp_len;
              r_beat    <= '0;
            end
          end
        end
        S_LOAD: begin
          if (w_wr_fire) begin
            r_loaded_count <= r_loaded_count + LP_CNT_ONE;
            if (wgt_in_last || w_last_slot) begin
              r_state <= S_IDLE;
            end
            // Filling the last slot while the stream still has words is an overflow.
            if (w_last_slot && !wgt_in_last) begin
              r_err <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          r_state <= S_CAPTURE;
        end
        S_CAPTURE, S_COMPUTE: begin
          if (act_valid) begin
            r_beat <= w_beat_next;
          end
          if (act_valid && (w_beat_next == r_len)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_COMPUTE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_weight_loader.sv
// Self-checking bench for pe_weight_loader: a transaction-level model predicts every
// output each cycle; directed scenarios add hand-computed literal expectations.
module tb_pe_weight_loader;

  localparam int AW  = 3;
  localparam int WW  = 8;
  localparam int LW  = 16;
  localparam int CAP = 1 << AW;

  logic          clk;
  logic          reset_n;
  logic          wgt_in_valid;
  logic          wgt_in_ready;
  logic [WW-1:0] wgt_in_data;
  logic          wgt_in_last;
  logic          load_start;
  logic          comp_start;
  logic [AW-1:0] sel_addr;
  logic [LW-1:0] comp_len;
  logic          act_valid;
  logic          write_req_w_mem;
  logic [AW-1:0] w_addr_w_mem;
  logic [WW-1:0] w_data_w_mem;
  logic          read_req_w_mem;
  logic [AW-1:0] r_addr_w_mem;
  logic          reset_ws_reg;
  logic          ws_en;
  logic          ws_mux;
  logic          wrt_en_reg;
  logic [AW:0]   loaded_count;
  logic          busy;
  logic          done;
  logic          err;

  pe_weight_loader #(
    .MEM_ADDR_BITWIDTH(AW),
    .WGT_BITWIDTH     (WW),
    .LEN_BITWIDTH     (LW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .wgt_in_valid   (wgt_in_valid),
    .wgt_in_ready   (wgt_in_ready),
    .wgt_in_data    (wgt_in_data),
    .wgt_in_last    (wgt_in_last),
    .load_start     (load_start),
    .comp_start     (comp_start),
    .sel_addr       (sel_addr),
    .comp_len       (comp_len),
    .act_valid      (act_valid),
    .write_req_w_mem(write_req_w_mem),
    .w_addr_w_mem   (w_addr_w_mem),
    .w_data_w_mem   (w_data_w_mem),
    .read_req_w_mem (read_req_w_mem),
    .r_addr_w_mem   (r_addr_w_mem),
    .reset_ws_reg   (reset_ws_reg),
    .ws_en          (ws_en),
    .ws_mux         (ws_mux),
    .wrt_en_reg     (wrt_en_reg),
    .loaded_count   (loaded_count),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what is pending, not how the DUT sequences it. m_age counts cycles
  // since an accepted compute command (1 = fetch cycle, 2 = capture cycle, 3 = later).
  int        m_count   = 0;
  bit        m_loading = 0;
  int        m_age     = 0;
  int        m_beats   = 0;
  int        m_len     = 0;
  int        m_raddr   = 0;
  bit        m_done    = 0;
  bit        m_err     = 0;
  logic [WW-1:0] m_mem [CAP] = '{default: '0};
  logic [WW-1:0] sram  [CAP] = '{default: '0};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_count = 0; m_loading = 0; m_age = 0; m_beats = 0;
      m_len = 0; m_raddr = 0; m_done = 0; m_err = 0;
    end else begin
      m_done = 0;
      m_err  = 0;
      if (m_loading) begin
        if (wgt_in_valid) begin
          m_mem[m_count] = wgt_in_data;
          m_count++;
          if (wgt_in_last || m_count == CAP) begin
            m_loading = 0;
            if (!wgt_in_last) m_err = 1;
          end
        end
      end else if (m_age > 0) begin
        if (m_age >= 2 && act_valid) m_beats++;
        if (m_age >= 2 && m_beats == m_len) begin
          m_age  = 0;
          m_done = 1;
        end else begin
          m_age = (m_age < 3) ? m_age + 1 : 3;
        end
      end else if (load_start) begin
        m_loading = 1;
        m_count   = 0;
      end else if (comp_start) begin
        if (comp_len == 0 || int'(sel_addr) >= m_count) begin
          m_err = 1;
        end else begin
          m_age = 1; m_raddr = int'(sel_addr); m_beats = 0; m_len = int'(comp_len);
        end
      end
    end
  end

  int cnt_wr = 0, cnt_rd = 0, cnt_wrt = 0, cnt_done = 0, cnt_err = 0, cnt_wsen = 0;

  always @(negedge clk) begin
    bit exp_wr;
    exp_wr = m_loading && wgt_in_valid;
    check("wgt_in_ready", wgt_in_ready, m_loading);
    check("write_req", write_req_w_mem, exp_wr);
    if (exp_wr) begin
      check("w_addr", w_addr_w_mem, m_count);
      check("w_data", w_data_w_mem, wgt_in_data);
    end
    check("read_req", read_req_w_mem, m_age == 1);
    check("reset_ws_reg", reset_ws_reg, m_age == 1);
    check("r_addr", r_addr_w_mem, m_raddr);
    check("ws_en", ws_en, m_age == 2);
    check("ws_mux", ws_mux, m_age == 2);
    check("wrt_en_reg", wrt_en_reg, (m_age >= 2) && act_valid);
    check("loaded_count", loaded_count, m_count);
    check("busy", busy, m_loading || (m_age > 0));
    check("done", done, m_done);
    check("err", err, m_err);
    if (write_req_w_mem) begin
      cnt_wr++;
      sram[w_addr_w_mem] = w_data_w_mem;
    end
    if (read_req_w_mem) begin
      cnt_rd++;
      check("fetched_weight", sram[r_addr_w_mem], m_mem[r_addr_w_mem]);
    end
    if (wrt_en_reg) cnt_wrt++;
    if (done)       cnt_done++;
    if (err)        cnt_err++;
    if (ws_en)      cnt_wsen++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_burst(input int n, input bit with_last, input int gap_pct, input bit rand_data);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        wgt_in_valid = 1'b0;
        step();
      end
      wgt_in_valid = 1'b1;
      wgt_in_data  = rand_data ? 8'($urandom) : 8'((i + 1) * 17);
      wgt_in_last  = with_last && (i == n - 1);
      step();
    end
    wgt_in_valid = 1'b0;
    wgt_in_last  = 1'b0;
    step();
  endtask

  // pat[i] is act_valid for the i-th cycle after the command cycle (bit 0 = fetch cycle).
  task automatic run_pass(input int sel, input int len, input logic [15:0] pat, input int pat_len);
    comp_start = 1'b1;
    sel_addr   = sel[AW-1:0];
    comp_len   = len[LW-1:0];
    step();
    comp_start = 1'b0;
    for (int i = 0; i < pat_len; i++) begin
      act_valid = pat[i];
      step();
    end
    act_valid = 1'b0;
    for (int i = 0; i < 20 && busy; i++) step();
    check("pass_returns_idle", busy, 1'b0);
    step();
  endtask

  int b_wr, b_rd, b_wrt, b_done, b_err, b_wsen;

  task automatic snap();
    b_wr = cnt_wr; b_rd = cnt_rd; b_wrt = cnt_wrt;
    b_done = cnt_done; b_err = cnt_err; b_wsen = cnt_wsen;
  endtask

  initial begin
    reset_n = 1'b0; wgt_in_valid = 1'b0; wgt_in_data = '0; wgt_in_last = 1'b0;
    load_start = 1'b0; comp_start = 1'b0; sel_addr = '0; comp_len = '0; act_valid = 1'b0;
    repeat (3) step();
    check("rst_busy", busy, 1'b0);
    check("rst_loaded_count", loaded_count, 0);
    check("rst_ready", wgt_in_ready, 1'b0);
    reset_n = 1'b1;
    step();

    // Four-word burst with last on the fourth word.
    snap();
    load_burst(4, 1'b1, 0, 1'b0);
    check("load4_writes", cnt_wr - b_wr, 4);
    check("load4_count", loaded_count, 4);
    check("load4_no_err", cnt_err - b_err, 0);
    check("load4_idle", busy, 1'b0);

    // sel=2, len=3, act held high.
    snap();
    run_pass(2, 3, 16'hffff, 8);
    check("pass1_wrt_beats", cnt_wrt - b_wrt, 3);
    check("pass1_done", cnt_done - b_done, 1);
    check("pass1_ws_en", cnt_wsen - b_wsen, 1);
    check("pass1_reads", cnt_rd - b_rd, 1);
    check("pass1_raddr_held", r_addr_w_mem, 2);

    // Same pass with act 1,0,0,1,1 starting at the capture cycle.
    snap();
    run_pass(2, 3, 16'b11_0011, 6);
    check("pass2_wrt_beats", cnt_wrt - b_wrt, 3);
    check("pass2_done", cnt_done - b_done, 1);
    check("pass2_ws_en", cnt_wsen - b_wsen, 1);

    // Rejected commands: address beyond the loaded weights, and zero length.
    snap();
    comp_start = 1'b1; sel_addr = 3'd4; comp_len = 16'd3;
    step();
    comp_start = 1'b0;
    check("rej_addr_err_pulse", err, 1'b1);
    step();
    comp_start = 1'b1; sel_addr = 3'd1; comp_len = 16'd0;
    step();
    comp_start = 1'b0;
    check("rej_len_err_pulse", err, 1'b1);
    step();
    check("rej_err_count", cnt_err - b_err, 2);
    check("rej_no_read", cnt_rd - b_rd, 0);
    check("rej_idle", busy, 1'b0);

    // Overflow: stream CAP+2 words with no last.
    snap();
    load_burst(CAP + 2, 1'b0, 0, 1'b1);
    check("ovf_writes", cnt_wr - b_wr, CAP);
    check("ovf_err", cnt_err - b_err, 1);
    check("ovf_count", loaded_count, CAP);
    check("ovf_not_ready", wgt_in_ready, 1'b0);

    // Exactly full burst ending in last is not an overflow.
    snap();
    load_burst(CAP, 1'b1, 30, 1'b1);
    check("full_writes", cnt_wr - b_wr, CAP);
    check("full_no_err", cnt_err - b_err, 0);
    check("full_count", loaded_count, CAP);
    snap();
    run_pass(CAP - 1, 1, 16'b10, 2);
    check("len1_done", cnt_done - b_done, 1);
    check("len1_wrt", cnt_wrt - b_wrt, 1);

    // Randomized traffic, including commands while busy and simultaneous starts.
    for (int c = 0; c < 1500; c++) begin
      load_start   = ($urandom_range(19) == 0);
      comp_start   = ($urandom_range(7) == 0);
      wgt_in_valid = ($urandom_range(3) != 0);
      wgt_in_data  = 8'($urandom);
      wgt_in_last  = ($urandom_range(4) == 0);
      act_valid    = ($urandom_range(1) == 1);
      sel_addr     = 3'($urandom_range(CAP - 1));
      comp_len     = 16'($urandom_range(6));
      step();
    end
    load_start = 1'b0; comp_start = 1'b0;
    wgt_in_valid = 1'b1; wgt_in_last = 1'b1; act_valid = 1'b1;
    repeat (12) step();
    wgt_in_valid = 1'b0; wgt_in_last = 1'b0; act_valid = 1'b0;
    step();
    check("rand_drained", busy, 1'b0);

    // Reset while stalled in a compute pass.
    load_burst(3, 1'b1, 0, 1'b0);
    comp_start = 1'b1; sel_addr = 3'd0; comp_len = 16'd5;
    step();
    comp_start = 1'b0;
    act_valid = 1'b0;
    step();
    act_valid = 1'b1;
    step();
    act_valid = 1'b0;
    repeat (2) step();
    check("stall_busy", busy, 1'b1);
    snap();
    act_valid = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_wrt_en", wrt_en_reg, 1'b0);
    check("arst_loaded_count", loaded_count, 0);
    check("arst_ws_mux", ws_mux, 1'b0);
    check("arst_done", done, 1'b0);
    repeat (2) step();
    check("arst_no_done", cnt_done - b_done, 0);
    act_valid = 1'b0;
    reset_n = 1'b1;
    step();
    snap();
    load_burst(2, 1'b1, 0, 1'b1);
    check("post_rst_writes", cnt_wr - b_wr, 2);
    check("post_rst_count", loaded_count, 2);
    run_pass(1, 2, 16'hffff, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
